// File: rtl/conv_layer_mc.sv
// Multi-channel, multi-filter 1-D convolution layer: buffers one input frame, runs
// NUM_FILTERS kernels in parallel over every output position, holds the map for a yumi.

module ROM_neuron #(
    parameter int LAYER_NUMBER  = 1,
    parameter int NEURON_NUMBER = 0,
    parameter int WORD_SIZE     = 16,
    parameter int INT_BITS      = 4,
    parameter int NUM_WEIGHTS   = 6,
    parameter int ADDR_W        = 3
) (
    input  logic                        clk_i,
    input  logic [ADDR_W-1:0]           addr_i,
    output logic signed [WORD_SIZE-1:0] data_o
);
    localparam int F = WORD_SIZE - INT_BITS;
    localparam logic signed [WORD_SIZE-1:0] ONE  = WORD_SIZE'(1) <<< F;
    localparam logic signed [WORD_SIZE-1:0] HALF = ONE >>> 1;

    // Words below NUM_WEIGHTS are kernel weights; anything above reads the bias.
    function automatic logic signed [WORD_SIZE-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic signed [WORD_SIZE-1:0] w;
        logic signed [WORD_SIZE-1:0] b;
        w = '0;
        b = '0;
        if (LAYER_NUMBER == 1) begin
            case (NEURON_NUMBER)
                0, 1:    w = ONE;
                2:       begin w = -ONE; b = HALF; end
                3:       w = -ONE;
                default: w = '0;
            endcase
        end
        return (int'(a) < NUM_WEIGHTS) ? w : b;
    endfunction

    always_ff @(posedge clk_i) begin
        data_o <= rom_word(addr_i);
    end
endmodule

module conv_layer_mc #(
    parameter int INPUT_LENGTH  = 8,
    parameter int CHANNELS      = 2,
    parameter int KERNEL_HEIGHT = 3,
    parameter int NUM_FILTERS   = 4,
    parameter int STRIDE        = 1,
    parameter int WORD_SIZE     = 16,
    parameter int INT_BITS      = 4,
    parameter int RELU          = 0,
    parameter int LAYER_NUMBER  = 1,
    parameter int FILTER_BASE   = 0,
    localparam int KC           = KERNEL_HEIGHT * CHANNELS,
    localparam int OUT_LEN      = (INPUT_LENGTH - KERNEL_HEIGHT) / STRIDE + 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      start_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic signed [WORD_SIZE-1:0]               data_i,
    output logic                                      valid_o,
    input  logic                                      yumi_i,
    output logic [NUM_FILTERS*OUT_LEN*WORD_SIZE-1:0]  data_o,
    output logic                                      sat_o
);
    localparam int F      = WORD_SIZE - INT_BITS;
    localparam int NWORDS = INPUT_LENGTH * CHANNELS;
    localparam int NW_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int KW     = $clog2(KC + 2);
    localparam int AW     = 2 * WORD_SIZE + $clog2(KC + 1);
    localparam int NOUT   = NUM_FILTERS * OUT_LEN;

    localparam logic signed [WORD_SIZE-1:0] W_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [WORD_SIZE-1:0] W_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-WORD_SIZE){1'b0}}, W_MAX};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-WORD_SIZE){1'b1}}, W_MIN};

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t                      state, state_nxt;
    logic [NW_W-1:0]             n_cnt;
    logic [KW-1:0]               k_cnt;
    logic                        vld_p1;
    logic [KW-1:0]               k_p1;
    logic signed [WORD_SIZE-1:0] buffer [NWORDS];
    logic signed [WORD_SIZE-1:0] rom_q_p1 [NUM_FILTERS];
    logic signed [AW-1:0]        acc     [NUM_FILTERS][OUT_LEN];
    logic signed [AW-1:0]        acc_nxt [NUM_FILTERS][OUT_LEN];
    logic signed [2*WORD_SIZE-1:0] prod;
    logic [WORD_SIZE:0]          rs;
    logic [NOUT*WORD_SIZE-1:0]   map_nxt;
    logic [NOUT-1:0]             sat_vec;
    logic                        accept, last_word, issue_p0, last_acc, frame_start;

    function automatic logic signed [2*WORD_SIZE-1:0] mul_full(
        input logic signed [WORD_SIZE-1:0] a,
        input logic signed [WORD_SIZE-1:0] b
    );
        logic signed [2*WORD_SIZE-1:0] ax;
        logic signed [2*WORD_SIZE-1:0] bx;
        ax = {{WORD_SIZE{a[WORD_SIZE-1]}}, a};
        bx = {{WORD_SIZE{b[WORD_SIZE-1]}}, b};
        return ax * bx;
    endfunction

    // Arithmetic shift truncates toward -inf; MSB of the result flags a clip.
    function automatic logic [WORD_SIZE:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> F;
        if (s > SAT_HI) return {1'b1, W_MAX};
        if (s < SAT_LO) return {1'b1, W_MIN};
        return {1'b0, s[WORD_SIZE-1:0]};
    endfunction

    function automatic logic [WORD_SIZE-1:0] relu(input logic [WORD_SIZE-1:0] v);
        return (RELU != 0 && v[WORD_SIZE-1]) ? '0 : v;
    endfunction

    assign accept      = (state == LOAD) && valid_i;
    assign last_word   = accept && (n_cnt == NW_W'(NWORDS - 1));
    assign issue_p0    = (state == COMPUTE) && (k_cnt <= KW'(KC));
    assign last_acc    = vld_p1 && (k_p1 == KW'(KC));
    assign frame_start = (state == IDLE) && start_i;
    assign ready_o     = (state == LOAD);
    assign valid_o     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)   state_nxt = LOAD;
            LOAD:    if (last_word) state_nxt = COMPUTE;
            COMPUTE: if (last_acc)  state_nxt = DONE;
            DONE:    if (yumi_i)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state  <= IDLE;
            n_cnt  <= '0;
            k_cnt  <= '0;
            vld_p1 <= 1'b0;
            k_p1   <= '0;
            sat_o  <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue_p0;
            k_p1   <= k_cnt;
            if (frame_start) begin
                n_cnt <= '0;
                k_cnt <= '0;
                sat_o <= 1'b0;
            end else begin
                if (accept)   n_cnt <= n_cnt + 1'b1;
                if (issue_p0) k_cnt <= k_cnt + 1'b1;
                if (last_acc) sat_o <= |sat_vec;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) buffer[n_cnt] <= data_i;
    end

    // Stage p0 -> p1: one ROM per filter, all addressed by the shared k counter.
    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_rom
        ROM_neuron #(
            .LAYER_NUMBER (LAYER_NUMBER),
            .NEURON_NUMBER(FILTER_BASE + g),
            .WORD_SIZE    (WORD_SIZE),
            .INT_BITS     (INT_BITS),
            .NUM_WEIGHTS  (KC),
            .ADDR_W       (KW)
        ) u_rom (
            .clk_i (clk_i),
            .addr_i(k_cnt),
            .data_o(rom_q_p1[g])
        );
    end

    // Stage p1: multiply-accumulate every (filter, position) pair with the current ROM word.
    always_comb begin
        prod = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int p = 0; p < OUT_LEN; p++) begin
                acc_nxt[f][p] = acc[f][p];
                if (k_p1 < KW'(KC)) begin
                    prod = mul_full(rom_q_p1[f],
                                    buffer[NW_W'(p*STRIDE*CHANNELS) + NW_W'(k_p1)]);
                    acc_nxt[f][p] = acc[f][p]
                                  + {{(AW-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
                end else begin
                    acc_nxt[f][p] = acc[f][p]
                                  + ({{(AW-WORD_SIZE){rom_q_p1[f][WORD_SIZE-1]}}, rom_q_p1[f]} <<< F);
                end
            end
        end
    end

    always_comb begin
        rs      = '0;
        map_nxt = '0;
        sat_vec = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int p = 0; p < OUT_LEN; p++) begin
                rs = round_sat(acc_nxt[f][p]);
                sat_vec[f*OUT_LEN+p] = rs[WORD_SIZE];
                map_nxt[(f*OUT_LEN+p)*WORD_SIZE +: WORD_SIZE] = relu(rs[WORD_SIZE-1:0]);
            end
        end
    end

    // Stage p1 -> output: the bias word's accumulate also registers the finished map.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || frame_start) begin
            for (int f = 0; f < NUM_FILTERS; f++)
                for (int p = 0; p < OUT_LEN; p++)
                    acc[f][p] <= '0;
            data_o <= '0;
        end else if (vld_p1) begin
            acc <= acc_nxt;
            if (last_acc) data_o <= map_nxt;
        end
    end
endmodule

// File: tb/tb_conv_layer_mc.sv
// Directed vector bench for conv_layer_mc: four configurations share clock, reset and data.

module tb_conv_layer_mc;
    localparam int NDUT = 4;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [15:0] data_i;
    logic        start_s [NDUT];
    logic        valid_s [NDUT];
    logic        yumi_s  [NDUT];
    logic        ready_s [NDUT];
    logic        vo_s    [NDUT];
    logic        sat_s   [NDUT];
    logic [63:0] do_s    [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    // A: ones filters; B: filter 1 is -1.0 with +0.5 bias; C: B with ReLU; D: stride 2.
    conv_layer_mc #(.INPUT_LENGTH(4), .NUM_FILTERS(2), .FILTER_BASE(0), .RELU(0)) u_a (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_s[0]), .valid_i(valid_s[0]),
        .ready_o(ready_s[0]), .data_i(data_i), .valid_o(vo_s[0]), .yumi_i(yumi_s[0]),
        .data_o(do_s[0]), .sat_o(sat_s[0]));
    conv_layer_mc #(.INPUT_LENGTH(4), .NUM_FILTERS(2), .FILTER_BASE(1), .RELU(0)) u_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_s[1]), .valid_i(valid_s[1]),
        .ready_o(ready_s[1]), .data_i(data_i), .valid_o(vo_s[1]), .yumi_i(yumi_s[1]),
        .data_o(do_s[1]), .sat_o(sat_s[1]));
    conv_layer_mc #(.INPUT_LENGTH(4), .NUM_FILTERS(2), .FILTER_BASE(1), .RELU(1)) u_c (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_s[2]), .valid_i(valid_s[2]),
        .ready_o(ready_s[2]), .data_i(data_i), .valid_o(vo_s[2]), .yumi_i(yumi_s[2]),
        .data_o(do_s[2]), .sat_o(sat_s[2]));
    conv_layer_mc #(.INPUT_LENGTH(5), .STRIDE(2), .NUM_FILTERS(2), .FILTER_BASE(0), .RELU(0)) u_d (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_s[3]), .valid_i(valid_s[3]),
        .ready_o(ready_s[3]), .data_i(data_i), .valid_o(vo_s[3]), .yumi_i(yumi_s[3]),
        .data_o(do_s[3]), .sat_o(sat_s[3]));

    typedef struct {
        int          dut;
        int          mode;     // 0: constant word, 1: row ramp r*0x0100
        logic [15:0] val;
        bit          gaps;     // random valid gaps, yumi delay, stray start pulses
        logic [63:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] stim(input int mode, input logic [15:0] val, input int n);
        return (mode == 1) ? 16'((n / 2) * 256) : val;
    endfunction

    task automatic run_frame(input int d, input int mode, input logic [15:0] val, input bit gaps,
                             output int lat, output logic [63:0] dout, output logic sat);
        int n;
        int nwords;
        int guard;
        nwords = (d == 3) ? 10 : 8;
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
        n = 0;
        guard = 0;
        while (n < nwords && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid_s[d] = 1'b0;
                data_i     = 16'hDEAD;
            end else begin
                valid_s[d] = 1'b1;
                data_i     = stim(mode, val, n);
            end
            if (valid_s[d] && ready_s[d]) n++;
            tick();
            guard++;
        end
        valid_s[d] = 1'b0;
        data_i     = 16'hDEAD;
        check($sformatf("d%0d_load_accepts", d), 64'(n), 64'(nwords));
        lat = 0;
        while (!vo_s[d] && lat < 40) begin
            start_s[d] = (gaps && lat == 2);
            tick();
            lat++;
        end
        start_s[d] = 1'b0;
        dout = do_s[d];
        sat  = sat_s[d];
        if (gaps) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("d%0d_hold_data", d), do_s[d], dout);
                check($sformatf("d%0d_hold_valid", d), 64'(vo_s[d]), 64'd1);
            end
        end
        yumi_s[d]  = 1'b1;
        start_s[d] = gaps;
        tick();
        yumi_s[d]  = 1'b0;
        start_s[d] = 1'b0;
        check($sformatf("d%0d_valid_after_yumi", d), 64'(vo_s[d]), 64'd0);
        tick();
        check($sformatf("d%0d_no_restart", d), 64'(ready_s[d]), 64'd0);
        check($sformatf("d%0d_data_kept", d), do_s[d], dout);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] dout;
        logic        sat;

        reset_n_i = 1'b0;
        data_i    = '0;
        for (int i = 0; i < NDUT; i++) begin
            start_s[i] = 1'b0;
            valid_s[i] = 1'b0;
            yumi_s[i]  = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_ready_d%0d", i), 64'(ready_s[i]), 64'd0);
            check($sformatf("rst_valid_d%0d", i), 64'(vo_s[i]), 64'd0);
            check($sformatf("rst_sat_d%0d", i), 64'(sat_s[i]), 64'd0);
            check($sformatf("rst_data_d%0d", i), do_s[i], 64'd0);
        end
        reset_n_i = 1'b1;
        tick();

        vecs[0] = '{0, 0, 16'h1000, 1'b0, 64'h6000_6000_6000_6000, 1'b0};
        vecs[1] = '{1, 0, 16'h1000, 1'b0, 64'hA800_A800_6000_6000, 1'b0};
        vecs[2] = '{2, 0, 16'h1000, 1'b0, 64'h0000_0000_6000_6000, 1'b0};
        vecs[3] = '{0, 0, 16'h7FFF, 1'b0, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1};
        vecs[4] = '{1, 0, 16'h7FFF, 1'b0, 64'h8000_8000_7FFF_7FFF, 1'b1};
        vecs[5] = '{2, 0, 16'h7FFF, 1'b0, 64'h0000_0000_7FFF_7FFF, 1'b1};
        vecs[6] = '{3, 1, 16'h0000, 1'b0, 64'h1200_0600_1200_0600, 1'b0};
        vecs[7] = '{0, 0, 16'hF000, 1'b0, 64'hA000_A000_A000_A000, 1'b0};
        vecs[8] = '{0, 0, 16'h1000, 1'b1, 64'h6000_6000_6000_6000, 1'b0};
        vecs[9] = '{3, 1, 16'h0000, 1'b1, 64'h1200_0600_1200_0600, 1'b0};

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].dut, vecs[i].mode, vecs[i].val, vecs[i].gaps, lat, dout, sat);
            check($sformatf("v%0d_data", i), dout, vecs[i].exp_data);
            check($sformatf("v%0d_sat", i), 64'(sat), 64'(vecs[i].exp_sat));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
        end

        // Abort a frame on configuration A after three words, then run a clean one.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_s[0] = 1'b1;
            data_i     = 16'h7FFF;
            tick();
        end
        valid_s[0] = 1'b0;
        reset_n_i  = 1'b0;
        tick();
        check("midrst_ready", 64'(ready_s[0]), 64'd0);
        check("midrst_valid", 64'(vo_s[0]), 64'd0);
        check("midrst_data", do_s[0], 64'd0);
        reset_n_i = 1'b1;
        tick();
        check("postrst_ready", 64'(ready_s[0]), 64'd0);
        run_frame(0, 0, 16'h1000, 1'b0, lat, dout, sat);
        check("postrst_data", dout, 64'h6000_6000_6000_6000);
        check("postrst_sat", 64'(sat), 64'd0);
        check("postrst_latency", 64'(lat), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
